// File: rtl/vga_pkg.sv
// Display constants and the sweep state encoding shared by the sprite bank.
package vga_pkg;

  localparam int VGA_CW       = 12;
  localparam int VGA_D_WIDTH  = 640;
  localparam int VGA_D_HEIGHT = 480;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis bounce step: advances a coordinate by spd toward dir and reflects off [lo, hi].
module sprite_axis_step #(
  parameter int CW    = 12,
  parameter int SPD_W = 4
) (
  input  logic [CW-1:0]    pos_i,
  input  logic             dir_i,
  input  logic [SPD_W-1:0] spd_i,
  input  logic [CW-1:0]    lo_i,
  input  logic [CW-1:0]    hi_i,
  output logic [CW-1:0]    pos_o,
  output logic             dir_o,
  output logic             hit_o
);

  logic [CW:0] pos_w, spd_w, lo_w, hi_w, fwd_w, thr_w;

  // One extra bit keeps pos+spd and lo+spd from wrapping near the top of the range.
  always_comb begin
    pos_w = {1'b0, pos_i};
    spd_w = (CW+1)'(spd_i);
    lo_w  = {1'b0, lo_i};
    hi_w  = {1'b0, hi_i};
    fwd_w = pos_w + spd_w;
    thr_w = lo_w + spd_w;
    pos_o = pos_i;
    dir_o = dir_i;
    hit_o = 1'b0;
    if (spd_i != '0) begin
      if (dir_i) begin
        if (fwd_w >= hi_w) begin
          pos_o = hi_i;
          dir_o = 1'b0;
          hit_o = 1'b1;
        end else begin
          pos_o = fwd_w[CW-1:0];
        end
      end else begin
        if (pos_w <= thr_w) begin
          pos_o = lo_i;
          dir_o = 1'b1;
          hit_o = 1'b1;
        end else begin
          pos_o = pos_i - CW'(spd_i);
        end
      end
    end
  end

endmodule

// File: rtl/sprite_bank.sv
// Bank of bouncing objects: per-object state in register arrays, updated one object per
// cycle by a single shared X/Y step datapath on each animation strobe.
module sprite_bank
  import vga_pkg::*;
#(
  parameter int N_OBJ    = 4,
  parameter int H_WIDTH  = 20,
  parameter int H_HEIGHT = 20,
  parameter int D_WIDTH  = VGA_D_WIDTH,
  parameter int D_HEIGHT = VGA_D_HEIGHT,
  parameter int CW       = VGA_CW,
  parameter int SPD_W    = 4,
  localparam int IDW     = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ani_stb,
  input  logic               i_animate,
  input  logic               i_ld_valid,
  output logic               o_ld_ready,
  input  logic [IDW-1:0]     i_ld_id,
  input  logic [CW-1:0]      i_ld_x,
  input  logic [CW-1:0]      i_ld_y,
  input  logic               i_ld_xdir,
  input  logic               i_ld_ydir,
  input  logic [SPD_W-1:0]   i_ld_spd,
  output logic [N_OBJ*CW-1:0] o_x1,
  output logic [N_OBJ*CW-1:0] o_x2,
  output logic [N_OBJ*CW-1:0] o_y1,
  output logic [N_OBJ*CW-1:0] o_y2,
  output logic [N_OBJ-1:0]   o_hit,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam int L_I = H_WIDTH;
  localparam int R_I = D_WIDTH - 1 - H_WIDTH;
  localparam int T_I = H_HEIGHT;
  localparam int B_I = D_HEIGHT - 1 - H_HEIGHT;

  localparam logic [CW-1:0]    L_C     = CW'(L_I);
  localparam logic [CW-1:0]    R_C     = CW'(R_I);
  localparam logic [CW-1:0]    T_C     = CW'(T_I);
  localparam logic [CW-1:0]    B_C     = CW'(B_I);
  localparam logic [CW-1:0]    X_RST   = CW'(D_WIDTH / 2);
  localparam logic [CW-1:0]    Y_RST   = CW'(D_HEIGHT / 2);
  localparam logic [SPD_W-1:0] SPD_RST = SPD_W'(1);

  sweep_state_e     state_q, state_d;
  logic [IDW-1:0]   idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic [N_OBJ-1:0] hit_q, hit_d;

  logic [CW-1:0]    x_q   [N_OBJ];
  logic [CW-1:0]    y_q   [N_OBJ];
  logic [SPD_W-1:0] spd_q [N_OBJ];
  logic [N_OBJ-1:0] xdir_q, ydir_q;

  logic             stb, in_sweep, last_idx, ld_fire, ld_id_ok;
  logic [CW-1:0]    nxt_x, nxt_y, ld_x_c, ld_y_c;
  logic             nxt_xdir, nxt_ydir, hit_x, hit_y;

  assign stb        = i_ani_stb && i_animate;
  assign in_sweep   = (state_q == ST_SWEEP);
  assign last_idx   = (idx_q == IDW'(N_OBJ - 1));
  assign o_ld_ready = (state_q == ST_IDLE) && !pending_q;
  assign ld_fire    = i_ld_valid && o_ld_ready;
  assign o_busy     = in_sweep;
  assign o_overrun  = overrun_q;
  assign o_hit      = hit_q;

  // Out-of-range ids are handshaken but never written.
  generate
    if ((1 << IDW) == N_OBJ) begin : g_id_full
      assign ld_id_ok = 1'b1;
    end else begin : g_id_part
      assign ld_id_ok = (i_ld_id < IDW'(N_OBJ));
    end
  endgenerate

  assign ld_x_c = CW'(clamp_int(int'(i_ld_x), L_I, R_I));
  assign ld_y_c = CW'(clamp_int(int'(i_ld_y), T_I, B_I));

  sprite_axis_step #(.CW(CW), .SPD_W(SPD_W)) u_step_x (
    .pos_i (x_q[idx_q]),
    .dir_i (xdir_q[idx_q]),
    .spd_i (spd_q[idx_q]),
    .lo_i  (L_C),
    .hi_i  (R_C),
    .pos_o (nxt_x),
    .dir_o (nxt_xdir),
    .hit_o (hit_x)
  );

  sprite_axis_step #(.CW(CW), .SPD_W(SPD_W)) u_step_y (
    .pos_i (y_q[idx_q]),
    .dir_i (ydir_q[idx_q]),
    .spd_i (spd_q[idx_q]),
    .lo_i  (T_C),
    .hi_i  (B_C),
    .pos_o (nxt_y),
    .dir_o (nxt_ydir),
    .hit_o (hit_y)
  );

  // A strobe that lands on the final sweep cycle, or a pending one, chains straight into a new sweep.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (stb) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (last_idx) begin
          if (pending_q) begin
            idx_d     = '0;
            pending_d = stb;
          end else if (stb) begin
            idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d = idx_q + 1'b1;
          if (stb) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hit_d = '0;
    if (in_sweep) hit_d[idx_q] = hit_x | hit_y;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      hit_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      hit_q     <= hit_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_OBJ; i++) begin
        x_q[i]    <= X_RST;
        y_q[i]    <= Y_RST;
        spd_q[i]  <= SPD_RST;
        xdir_q[i] <= (i % 2 == 0);
        ydir_q[i] <= (i % 2 == 0);
      end
    end else if (ld_fire && ld_id_ok) begin
      x_q[i_ld_id]    <= ld_x_c;
      y_q[i_ld_id]    <= ld_y_c;
      spd_q[i_ld_id]  <= i_ld_spd;
      xdir_q[i_ld_id] <= i_ld_xdir;
      ydir_q[i_ld_id] <= i_ld_ydir;
    end else if (in_sweep) begin
      x_q[idx_q]    <= nxt_x;
      y_q[idx_q]    <= nxt_y;
      xdir_q[idx_q] <= nxt_xdir;
      ydir_q[idx_q] <= nxt_ydir;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OBJ; gi++) begin : g_edges
      assign o_x1[gi*CW +: CW] = x_q[gi] - CW'(H_WIDTH);
      assign o_x2[gi*CW +: CW] = x_q[gi] + CW'(H_WIDTH);
      assign o_y1[gi*CW +: CW] = y_q[gi] - CW'(H_HEIGHT);
      assign o_y2[gi*CW +: CW] = y_q[gi] + CW'(H_HEIGHT);
    end
  endgenerate

endmodule
